// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory channel between the fetch queue (master) and the
// instruction memory (slave). Requests use valid/ready. Responses come back
// in request order and have no backpressure.
interface fetch_queue_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front-end placed ahead of the IF/ID register.
// - Generates sequential word-aligned PCs.
// - Issues requests to instruction memory.
// - Buffers in-order responses in a DEPTH-entry queue tagged with their PC.
// - Handles MEM-stage redirects by flushing the queue and draining stale
//   responses that are still in flight.
// Optional build macro FETCH_BYPASS_EN: when the queue is empty, a response
// is forwarded combinationally to the IF_* outputs in the same cycle.
//
// state    | meaning
// ST_FETCH | normal operation: issue requests, enqueue responses
// ST_DRAIN | after a redirect: discard stale in-flight responses, no issue
module fetch_queue_unit #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  fetch_queue_unit_if.master       imem,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  input  logic                     ld_i,
  output logic                     if_valid_o,
  output logic [31:0]              if_instruction_o,
  output logic [31:0]              if_pc_o,
  output logic [31:0]              if_pc_add_result_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic {ST_FETCH = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          req_valid;
  logic          req_fire;
  logic          resp_live;
  logic          bypass;
  logic          q_pop;
  logic          push;
  logic [CW:0]   credit_sum;
  logic          head_valid;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = fetch_pc_q;

  // State register and datapath registers, synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage: write the response word and its PC tag at the tail
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem.resp_data;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Next-state logic: a redirect overrides everything, otherwise FETCH/DRAIN
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_i) begin
      // A response landing in the redirect cycle is stale and already counted.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = outst_q - CW'(resp_live);
      outst_d    = drop_d;
      state_d    = (drop_d != '0) ? ST_DRAIN : ST_FETCH;
    end else if (state_q == ST_FETCH) begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_live) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      outst_d = outst_q + CW'(req_fire) - CW'(resp_live);
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (q_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(q_pop);
    end else begin
      if (resp_live) begin
        drop_d  = drop_q - ONE_C;
        outst_d = outst_q - ONE_C;
        if (drop_q == ONE_C) begin
          state_d = ST_FETCH;
        end
      end
    end
  end

  // Output logic: issue credit check, head/bypass selection, push/pop strobes
  always_comb begin
    // A response with nothing outstanding is spurious and ignored.
    resp_live  = imem.resp_valid && (outst_q != '0);
    credit_sum = {1'b0, count_q} + {1'b0, outst_q};
    // Reserving a slot per outstanding request means a response never finds
    // the queue full.
    req_valid  = !rst_i && (state_q == ST_FETCH) && !redirect_i &&
                 (outst_q < MAX_OUT_C) && (credit_sum < DEPTH_C);
    req_fire   = req_valid && imem.req_ready;
    bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass     = !rst_i && (state_q == ST_FETCH) && !redirect_i &&
                 resp_live && (count_q == '0);
`endif
    head_valid = 1'b0;
    head_instr = 32'h0;
    head_pc    = 32'h0;
    if (bypass) begin
      head_valid = 1'b1;
      head_instr = imem.resp_data;
      head_pc    = resp_pc_q;
    end else if (count_q != '0) begin
      head_valid = 1'b1;
      head_instr = instr_mem_q[rd_ptr_q];
      head_pc    = pc_mem_q[rd_ptr_q];
    end
    if_valid_o         = head_valid;
    if_instruction_o   = head_instr;
    if_pc_o            = head_pc;
    if_pc_add_result_o = head_valid ? (head_pc + 32'd4) : 32'h0;
    count_o            = count_q;
    // A bypassed response that is consumed never touches the queue.
    q_pop = head_valid && ld_i && !redirect_i && !bypass;
    push  = !rst_i && (state_q == ST_FETCH) && !redirect_i && resp_live &&
            !(bypass && ld_i);
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          ld;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic [31:0]   if_add;
  logic [CW-1:0] count;

  fetch_queue_unit_if imem ();

  fetch_queue_unit #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .imem(imem),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .ld_i(ld),
    .if_valid_o(if_valid), .if_instruction_o(if_instr), .if_pc_o(if_pc),
    .if_pc_add_result_o(if_add), .count_o(count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: in-order pending requests with a due cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;
  req_t pend[$];
  int   cyc;
  int   lat_min, lat_max, resp_pct, spur_pct;
  bit   mem_hold;

  // Reference: next expected request PC, next expected delivered PC and the
  // number of current-stream instructions received but not yet consumed.
  logic [31:0] exp_fetch_pc, exp_if_pc;
  int          live;

  // Per-cycle observations (pre-edge) and matching expectations.
  logic          o_req_valid, o_fire, o_if_valid, o_pop, o_resp_real;
  logic [31:0]   o_req_addr, o_if_pc, o_if_instr, o_if_add;
  logic [CW-1:0] o_count;
  logic [31:0]   e_req_addr, e_if_pc;
  int            e_live, e_pend;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                      input bit l, input bit rdy);
    req_t tmp;
    @(negedge clk);
    rst            = r;
    redirect       = rd;
    redirect_pc    = rpc;
    ld             = l;
    imem.req_ready = rdy;
    imem.resp_valid = 1'b0;
    imem.resp_data  = $urandom;
    if (!r) begin
      if (pend.size() > 0) begin
        if (!mem_hold && pend[0].due <= cyc && $urandom_range(99) < resp_pct) begin
          imem.resp_valid = 1'b1;
          imem.resp_data  = instr_of(pend[0].addr);
        end
      end else if ($urandom_range(99) < spur_pct) begin
        imem.resp_valid = 1'b1;
      end
    end
    #1;
    o_req_valid = imem.req_valid;
    o_req_addr  = imem.req_addr;
    o_fire      = imem.req_valid && imem.req_ready;
    o_if_valid  = if_valid;
    o_if_pc     = if_pc;
    o_if_instr  = if_instr;
    o_if_add    = if_add;
    o_count     = count;
    o_pop       = !r && if_valid && l && !rd;
    o_resp_real = imem.resp_valid && (pend.size() > 0);
    e_req_addr  = exp_fetch_pc;
    e_if_pc     = exp_if_pc;
    e_live      = live;
    e_pend      = pend.size();
    @(posedge clk);
    if (r) begin
      pend.delete();
      exp_fetch_pc = RESET_PC;
      exp_if_pc    = RESET_PC;
      live         = 0;
    end else begin
      if (o_resp_real) begin
        if (!pend[0].stale && !rd) live++;
        tmp = pend.pop_front();
      end
      if (rd) begin
        exp_fetch_pc = {rpc[31:2], 2'b00};
        exp_if_pc    = {rpc[31:2], 2'b00};
        live         = 0;
        foreach (pend[i]) pend[i].stale = 1'b1;
      end else begin
        if (o_fire) exp_fetch_pc = exp_fetch_pc + 32'd4;
        if (o_pop) begin
          exp_if_pc = exp_if_pc + 32'd4;
          live--;
        end
      end
      if (o_fire) begin
        tmp.addr  = o_req_addr;
        tmp.due   = cyc + int'($urandom_range(lat_max, lat_min));
        tmp.stale = 1'b0;
        pend.push_back(tmp);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100; spur_pct = 0; mem_hold = 1'b0;
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100; spur_pct = 0; mem_hold = 1'b0;
    step(1, 0, 32'h0, 0, 1);
    total++;
    if (o_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_req_valid: got %b expected 0", o_req_valid);
    end
    step(1, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 0);
    total++;
    if (o_count !== '0) begin
      bad++; $display("FAIL reset_count: got %0d expected 0", o_count);
    end
    total++;
    if (o_if_valid !== 1'b0 || o_if_instr !== 32'h0 || o_if_pc !== 32'h0 || o_if_add !== 32'h0) begin
      bad++;
      $display("FAIL reset_if_outputs: got valid=%b instr=%h pc=%h add=%h expected all zero",
               o_if_valid, o_if_instr, o_if_pc, o_if_add);
    end
    total++;
    if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 %h",
                      o_req_valid, o_req_addr, RESET_PC);
    end
  endtask

  task automatic test_streaming();
    int fires = 0;
    int pops  = 0;
    bit seen  = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 32'h0, 1, 1);
      if (seen) begin
        total++;
        if (o_if_valid !== 1'b1) begin
          bad++; $display("FAIL stream_gap: cycle %0d got if_valid=%b expected 1", i, o_if_valid);
        end
      end
      if (o_fire) begin
        total++;
        if (o_req_addr !== e_req_addr) begin
          bad++; $display("FAIL stream_req_addr: got %h expected %h", o_req_addr, e_req_addr);
        end
        fires++;
      end
      if (o_pop) begin
        total++;
        if (o_if_pc !== e_if_pc || o_if_instr !== instr_of(e_if_pc) || o_if_add !== e_if_pc + 32'd4) begin
          bad++; $display("FAIL stream_head: got pc=%h instr=%h add=%h expected pc=%h instr=%h add=%h",
                          o_if_pc, o_if_instr, o_if_add, e_if_pc, instr_of(e_if_pc), e_if_pc + 32'd4);
        end
        if (pops == 0) begin
          total++;
          if (o_if_pc !== RESET_PC || o_if_add !== RESET_PC + 32'd4) begin
            bad++; $display("FAIL stream_first_head: got pc=%h add=%h expected %h %h",
                            o_if_pc, o_if_add, RESET_PC, RESET_PC + 32'd4);
          end
        end
        pops++;
        seen = 1'b1;
      end
    end
    total++;
    if (fires != 16) begin
      bad++; $display("FAIL stream_fire_count: got %0d expected 16", fires);
    end
    total++;
    if (pops < 14) begin
      bad++; $display("FAIL stream_pop_count: got %0d expected at least 14", pops);
    end
  endtask

  task automatic test_full();
    int fires = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 32'h0, 0, 1);
      if (o_fire) fires++;
    end
    total++;
    if (fires != DEPTH) begin
      bad++; $display("FAIL full_fire_count: got %0d expected %0d", fires, DEPTH);
    end
    total++;
    if (o_count !== CW'(DEPTH) || o_req_valid !== 1'b0) begin
      bad++; $display("FAIL full_state: got count=%0d req_valid=%b expected %0d 0",
                      o_count, o_req_valid, DEPTH);
    end
    step(0, 0, 32'h0, 1, 1);
    total++;
    if (o_pop !== 1'b1 || o_if_pc !== RESET_PC || o_if_instr !== instr_of(RESET_PC)) begin
      bad++; $display("FAIL full_pop: got pop=%b pc=%h instr=%h expected 1 %h %h",
                      o_pop, o_if_pc, o_if_instr, RESET_PC, instr_of(RESET_PC));
    end
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 32'h0, 0, 1);
      if (i == 0) begin
        total++;
        if (o_count !== CW'(DEPTH - 1)) begin
          bad++; $display("FAIL full_count_after_pop: got %0d expected %0d", o_count, DEPTH - 1);
        end
      end
      if (o_fire) begin
        fires++;
        total++;
        if (o_req_addr !== RESET_PC + 32'(4 * DEPTH)) begin
          bad++; $display("FAIL full_refill_addr: got %h expected %h", o_req_addr, RESET_PC + 32'(4 * DEPTH));
        end
      end
    end
    total++;
    if (fires != 1) begin
      bad++; $display("FAIL full_refill_count: got %0d expected 1", fires);
    end
  endtask

  task automatic test_redirect_inflight();
    int first_fire = -1;
    do_reset();
    mem_hold = 1'b1;
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    step(0, 1, 32'h0000_0103, 1, 1);
    total++;
    if (o_req_valid !== 1'b0 || e_pend != 2) begin
      bad++; $display("FAIL rdi_redirect_cycle: got req_valid=%b outstanding=%0d expected 0 2",
                      o_req_valid, e_pend);
    end
    step(0, 0, 32'h0, 1, 1);
    total++;
    if (o_count !== '0 || o_if_valid !== 1'b0 || o_req_valid !== 1'b0) begin
      bad++; $display("FAIL rdi_drain_idle: got count=%0d if_valid=%b req_valid=%b expected 0 0 0",
                      o_count, o_if_valid, o_req_valid);
    end
    mem_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 32'h0, 1, 1);
      if (i < 3) begin
        total++;
        if (o_if_valid !== 1'b0) begin
          bad++; $display("FAIL rdi_stale_visible: step %0d got if_valid=%b pc=%h expected 0",
                          i, o_if_valid, o_if_pc);
        end
      end
      if (o_fire && first_fire < 0) begin
        first_fire = i;
        total++;
        if (o_req_addr !== 32'h0000_0100) begin
          bad++; $display("FAIL rdi_target_addr: got %h expected 00000100", o_req_addr);
        end
      end
      if (o_pop) begin
        total++;
        if (o_if_pc !== e_if_pc || o_if_instr !== instr_of(e_if_pc)) begin
          bad++; $display("FAIL rdi_head: got pc=%h instr=%h expected %h %h",
                          o_if_pc, o_if_instr, e_if_pc, instr_of(e_if_pc));
        end
      end
    end
    total++;
    if (first_fire != 2) begin
      bad++; $display("FAIL rdi_resume_cycle: got %0d expected 2", first_fire);
    end
  endtask

  task automatic test_redirect_resp_ld();
    bit popped = 1'b0;
    do_reset();
    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    step(0, 1, 32'h0000_0200, 1, 0);
    total++;
    if (o_resp_real !== 1'b1 || o_if_valid !== 1'b1 || o_req_valid !== 1'b0) begin
      bad++; $display("FAIL rrl_redirect_cycle: got resp=%b if_valid=%b req_valid=%b expected 1 1 0",
                      o_resp_real, o_if_valid, o_req_valid);
    end
    step(0, 0, 32'h0, 1, 1);
    total++;
    if (o_count !== '0 || o_if_valid !== 1'b0) begin
      bad++; $display("FAIL rrl_dropped: got count=%0d if_valid=%b expected 0 0", o_count, o_if_valid);
    end
    total++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0000_0200) begin
      bad++; $display("FAIL rrl_next_req: got valid=%b addr=%h expected 1 00000200",
                      o_req_valid, o_req_addr);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'h0, 1, 1);
      if (o_pop && !popped) begin
        popped = 1'b1;
        total++;
        if (o_if_pc !== 32'h0000_0200 || o_if_add !== 32'h0000_0204) begin
          bad++; $display("FAIL rrl_first_head: got pc=%h add=%h expected 00000200 00000204",
                          o_if_pc, o_if_add);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic [31:0] adds[$];
    do_reset();
    step(0, 1, 32'hFFFF_FFFC, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 32'h0, 1, 1);
      if (o_fire) addrs.push_back(o_req_addr);
      if (o_pop) begin
        pcs.push_back(o_if_pc);
        adds.push_back(o_if_add);
      end
    end
    total++;
    if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_req_addrs: got n=%0d first=%h second=%h expected fffffffc 00000000",
                      addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hx,
                      (addrs.size() > 1) ? addrs[1] : 32'hx);
    end
    total++;
    if (pcs.size() < 2 || pcs[0] !== 32'hFFFF_FFFC || adds[0] !== 32'h0 || pcs[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_heads: got n=%0d pc0=%h add0=%h pc1=%h expected fffffffc 00000000 00000000",
                      pcs.size(), (pcs.size() > 0) ? pcs[0] : 32'hx,
                      (adds.size() > 0) ? adds[0] : 32'hx, (pcs.size() > 1) ? pcs[1] : 32'hx);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit popped = 1'b0;
    do_reset();
    mem_hold = 1'b1;
    step(0, 0, 32'h0, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    step(0, 1, 32'h0000_0300, 1, 1);
    step(1, 0, 32'h0, 0, 1);
    mem_hold = 1'b0;
    step(0, 0, 32'h0, 1, 1);
    total++;
    if (o_count !== '0 || o_if_valid !== 1'b0) begin
      bad++; $display("FAIL rmd_state: got count=%0d if_valid=%b expected 0 0", o_count, o_if_valid);
    end
    total++;
    if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin
      bad++; $display("FAIL rmd_req: got valid=%b addr=%h expected 1 %h", o_req_valid, o_req_addr, RESET_PC);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'h0, 1, 1);
      if (o_pop && !popped) begin
        popped = 1'b1;
        total++;
        if (o_if_pc !== RESET_PC || o_if_instr !== instr_of(RESET_PC)) begin
          bad++; $display("FAIL rmd_first_head: got pc=%h instr=%h expected %h %h",
                          o_if_pc, o_if_instr, RESET_PC, instr_of(RESET_PC));
        end
      end
    end
    total++;
    if (!popped) begin
      bad++; $display("FAIL rmd_no_delivery: got no instruction delivered expected one at %h", RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          rd, l, rdy;
    logic [31:0] tgt;
    do_reset();
    lat_min = 1; lat_max = 3; resp_pct = 70; spur_pct = 5;
    for (int i = 0; i < 1500; i++) begin
      rd  = ($urandom_range(99) < 4);
      l   = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < 70);
      tgt = $urandom;
      step(0, rd, tgt, l, rdy);
      if (o_fire) begin
        total++;
        if (o_req_addr !== e_req_addr) begin
          bad++; $display("FAIL rand_req_addr: cycle %0d got %h expected %h", i, o_req_addr, e_req_addr);
        end
      end
      if (o_req_valid) begin
        total++;
        if (rd || e_pend >= MAXO || e_live + e_pend >= DEPTH) begin
          bad++; $display("FAIL rand_issue_rule: cycle %0d got req_valid=1 expected 0 (redirect=%b outstanding=%0d queued=%0d)",
                          i, rd, e_pend, e_live);
        end
      end
      if (o_pop) begin
        total++;
        if (o_if_pc !== e_if_pc || o_if_instr !== instr_of(e_if_pc) || o_if_add !== e_if_pc + 32'd4) begin
          bad++; $display("FAIL rand_head: cycle %0d got pc=%h instr=%h add=%h expected %h %h %h",
                          i, o_if_pc, o_if_instr, o_if_add, e_if_pc, instr_of(e_if_pc), e_if_pc + 32'd4);
        end
      end
      total++;
      if (o_count !== CW'(e_live)) begin
        bad++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", i, o_count, e_live);
      end
      if (e_live > 0) begin
        total++;
        if (o_if_valid !== 1'b1) begin
          bad++; $display("FAIL rand_if_valid: cycle %0d got %b expected 1", i, o_if_valid);
        end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    ld              = 1'b0;
    imem.req_ready  = 1'b0;
    imem.resp_valid = 1'b0;
    imem.resp_data  = 32'h0;
    cyc             = 0;
    live            = 0;
    exp_fetch_pc    = RESET_PC;
    exp_if_pc       = RESET_PC;
    test_reset();
    test_streaming();
    test_full();
    test_redirect_inflight();
    test_redirect_resp_ld();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready channel.
- Buffers in-order responses in a DEPTH-entry queue, each entry tagged with its PC, and presents the head to IF/ID as instruction plus PC+4.
- Handles MEM-stage branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
DEPTH, 4, queue entries; power of 2, range 2..16
MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests, range 1..DEPTH
RESET_PC, 32'h00000000, fetch PC after reset

Ports:
Clk  in  1  clock
Rst  in  1  reset
IMemReqValid  out  1  request valid
IMemReqReady  in  1  memory accepts request
IMemReqAddr  out  32  request address, word aligned
IMemRespValid  in  1  response valid; responses return in request order
IMemRespData  in  32  instruction word
Redirect  in  1  taken branch/jump from MEM stage
RedirectPC  in  32  new fetch target
Ld  in  1  IF/ID load enable; consumer accepts the head this cycle
IF_Valid  out  1  head entry valid
IF_Instruction  out  32  head instruction
IF_PC  out  32  head PC
IF_PCAddResult  out  32  head PC+4, modulo 2^32
Count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Clock and reset: single clock Clk; Rst is synchronous, active-high.
- Reset values:
  - FetchPC = RespPC = RESET_PC.
  - Queue empty, Count = 0, Outstanding = 0, DropCnt = 0, state FETCH.
  - IF_Valid = 0; IF_Instruction, IF_PC and IF_PCAddResult = 0 while empty.
  - IMemReqValid = 0 in the reset cycle.
- Rst asserted mid-operation overrides everything, including Redirect and responses. Responses still in flight at reset are not tracked; the memory is reset on the same Rst.
- States:
  - FETCH: normal operation.
  - DRAIN: discarding stale responses after a redirect.
- Issue rule:
  - IMemReqValid = (state == FETCH) && !Redirect && (Outstanding < MAX_OUTSTANDING) && (Count + Outstanding < DEPTH).
  - This credit rule guarantees a response never finds the queue full.
  - IMemReqAddr = FetchPC. A request is accepted on IMemReqValid && IMemReqReady: FetchPC += 4 and Outstanding += 1.
- Response in FETCH:
  - Enqueue {IMemRespData, RespPC}, then RespPC += 4 and Outstanding -= 1.
  - Issue and response in the same cycle leave Outstanding unchanged.
- Dequeue: on IF_Valid && Ld && !Redirect. Push and pop in the same cycle leave Count unchanged. Ld while empty has no effect.
- Latency: a response accepted in cycle N gives IF_Valid = 1 in cycle N+1 when the queue was empty.
- Redirect (highest priority after Rst, in any state):
  - Queue cleared; FetchPC = RespPC = {RedirectPC[31:2], 2'b00}.
  - No request is issued and no pop occurs in that cycle.
  - A response arriving in the same cycle is discarded.
  - DropCnt = Outstanding − IMemRespValid. Next state is DRAIN if DropCnt > 0, else FETCH. Outstanding = DropCnt.
- DRAIN:
  - No requests are issued.
  - Each response is discarded and decrements DropCnt and Outstanding.
  - When the last stale response arrives (DropCnt == 1 with IMemRespValid), the next state is FETCH and issue resumes the following cycle.
  - A second Redirect during DRAIN recomputes DropCnt by the same rule and updates FetchPC.
- Wrap-around:
  - PC arithmetic wraps modulo 2^32: 32'hFFFFFFFC + 4 = 0.
  - Queue pointers wrap modulo DEPTH.
- Spurious response (IMemRespValid with Outstanding == 0) is ignored and has no state change.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the queue is empty, state is FETCH, IMemRespValid = 1 and !Redirect, the response drives IF_* combinationally in the same cycle with IF_Valid = 1.
  - If Ld = 1, the response is consumed and not enqueued.
  - If Ld = 0, it is enqueued normally.
- Undefined: minimum response-to-IF_Valid latency is 1 cycle; there is no combinational path from IMemResp* to IF_*.

Test Plan:
1. Reset then streaming: Rst 1 cycle, IMemReqReady = 1, memory latency 1, Ld = 1. Required: addresses 0, 4, 8, ... in order; IF_PC = 0 with IF_PCAddResult = 4, then IF_PC = 4 with IF_PCAddResult = 8, with no gaps after fill.
2. Backpressure/full: Ld = 0, DEPTH = 4. Required: exactly 4 requests issued, Count = 4, IMemReqValid = 0. Then Ld = 1 for one cycle: Count = 3 and exactly one new request is issued.
3. Redirect with in-flight responses: 2 outstanding, Redirect with RedirectPC = 32'h00000103, no response that cycle. Required: queue empty, DRAIN state, both following responses discarded, next request address = 32'h00000100.
4. Redirect with simultaneous response and Ld: Outstanding = 1, IMemRespValid = 1, Ld = 1, Redirect = 1. Required: no pop, response dropped, state FETCH, next request at the redirect target.
5. Wrap: RedirectPC = 32'hFFFFFFFC. Required: requests at 32'hFFFFFFFC then 32'h00000000; IF_PCAddResult for the first = 32'h00000000.
6. Rst mid-DRAIN: assert Rst while DropCnt = 2. Required: next cycle state FETCH, Count = 0, next request address = RESET_PC.
